// File: rtl/farm_pmi_arb.sv
`default_nettype none
// ============================================================================
// Module   : farm_pmi_arb
// Brief    : Round-robin N_CH-channel arbiter onto one word RAM, with
//            programmable wait states, byte enables and one-cycle mfc pulses.
//            Optional macro PMI_MISALIGN_TRAP_EN: trap misaligned accesses
//            (err pulse, no RAM write, data held).
// Revision : 1.0 - initial release
// ============================================================================
module farm_pmi_arb #(
    parameter int N_CH        = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            mem_rd,
    input  logic [N_CH-1:0]            mem_wr,
    input  logic [N_CH*ADDR_W-1:0]     address,
    input  logic [N_CH*DATA_W-1:0]     in_data,
    input  logic [N_CH*(DATA_W/8)-1:0] be,
    output logic [DATA_W-1:0]          data,
    output logic [N_CH-1:0]            mfc,
    output logic                       busy,
    output logic [N_CH-1:0]            err
);

    localparam int          c_BE_W      = DATA_W / 8;
    localparam int          c_OFF_SH    = $clog2(c_BE_W);
    localparam int          c_IDX_W     = $clog2(DEPTH);
    localparam int          c_GW        = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam bit          c_ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  c_CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [3:0]          r_cnt;
    logic [c_GW-1:0]     r_rr;
    logic [c_GW-1:0]     r_gnt;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_BE_W-1:0]   r_be;
    logic [DATA_W-1:0]   r_data;
    logic [N_CH-1:0]     r_mfc;
    logic [N_CH-1:0]     r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [N_CH-1:0]     w_req;
    logic                w_any;
    logic [c_GW-1:0]     w_gnt;
    logic [c_GW-1:0]     w_cand;
    logic                w_found;
    logic                w_in_wr;
    logic [ADDR_W-1:0]   w_in_addr;
    logic [DATA_W-1:0]   w_in_wdata;
    logic [c_BE_W-1:0]   w_in_be;
    logic [c_GW-1:0]     w_acc_gnt;
    logic                w_acc_wr;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic [c_BE_W-1:0]   w_acc_be;
    logic                w_acc_edge;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_mis;
    logic [N_CH-1:0]     w_onehot;

    assign w_req = mem_rd | mem_wr;
    assign w_any = |w_req;

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        w_gnt   = r_rr;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_cand = c_GW'((int'(r_rr) + i) % N_CH);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_in_wr    = mem_wr[w_gnt];
    assign w_in_addr  = address[w_gnt*ADDR_W +: ADDR_W];
    assign w_in_wdata = in_data[w_gnt*DATA_W +: DATA_W];
    assign w_in_be    = be[w_gnt*c_BE_W +: c_BE_W];

    // With zero wait states the access happens on the grant edge, before operands are latched.
    assign w_acc_gnt   = (r_state == S_IDLE) ? w_gnt      : r_gnt;
    assign w_acc_wr    = (r_state == S_IDLE) ? w_in_wr    : r_wr;
    assign w_acc_addr  = (r_state == S_IDLE) ? w_in_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? w_in_wdata : r_wdata;
    assign w_acc_be    = (r_state == S_IDLE) ? w_in_be    : r_be;

    assign w_acc_edge = rst_n &&
                        (((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                         (c_ZERO_WAIT && (r_state == S_IDLE) && w_any));

    assign w_idx = c_IDX_W'(w_acc_addr >> c_OFF_SH);

`ifdef PMI_MISALIGN_TRAP_EN
    assign w_mis = (w_acc_addr & ADDR_W'(c_BE_W - 1)) != '0;
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_onehot            = '0;
        w_onehot[w_acc_gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_acc_edge && w_acc_wr && !w_mis) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (w_acc_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_acc_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rr    <= c_GW'(N_CH - 1);
            r_gnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_data  <= '0;
            r_mfc   <= '0;
            r_err   <= '0;
        end else begin
            r_mfc <= '0;
            r_err <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_gnt;
                        r_wr    <= w_in_wr;
                        r_addr  <= w_in_addr;
                        r_wdata <= w_in_wdata;
                        r_be    <= w_in_be;
                        r_rr    <= w_gnt;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= c_ZERO_WAIT ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_acc_edge) begin
                r_mfc <= w_onehot;
                r_err <= w_mis ? w_onehot : '0;
                if (!w_acc_wr && !w_mis) begin
                    r_data <= r_mem[w_idx];
                end
            end
        end
    end

    assign data = r_data;
    assign mfc  = r_mfc;
    assign err  = r_err;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
